// File: rtl/dccm_pkg.sv
// Shared types for the DCCM TL-UL slave: queued response record and the
// init/run state of the array controller.
package dccm_pkg;

  localparam int MaxReadLatency = 2;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  size;
    logic [7:0]  source;
    logic [31:0] data;
    logic        error;
  } dccm_rsp_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } dccm_state_e;

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL bus types and opcode constants shared by hosts and device-side slaves.
// Only the fields the DCCM slave exchanges with the crossbar are modelled.
package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [7:0]  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [7:0]  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/dccm_rsp_fifo.sv
// In-order response queue for the DCCM; the head entry is presented from
// registers so the D channel has no combinational path from the array.
module dccm_rsp_fifo
  import dccm_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  dccm_rsp_t wdata_i,
  input  logic      ready_i,
  output logic      valid_o,
  output dccm_rsp_t rdata_o
);

  localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CW = $clog2(Depth + 1);

  dccm_rsp_t       storage [Depth];
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            valid_q, valid_d;
  dccm_rsp_t       rdata_q, rdata_d;
  logic            pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    pop     = valid_q && ready_i;
    wptr_d  = push_i ? ptr_inc(wptr_q) : wptr_q;
    rptr_d  = pop ? ptr_inc(rptr_q) : rptr_q;
    count_d = count_q + CW'(push_i) - CW'(pop);
    valid_d = (count_d != '0);
    rdata_d = '0;
    // The new head may be the entry being written this very cycle.
    if (count_d != '0) begin
      rdata_d = (push_i && (wptr_q == rptr_d)) ? wdata_i : storage[rptr_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      storage[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
    end
  end

  assign valid_o = valid_q;
  assign rdata_o = rdata_q;

endmodule

// File: rtl/dccm_tlul.sv
// TL-UL data memory slave: byte-masked word array, fixed-latency response
// pipeline, credit-limited outstanding requests and optional zero-fill on reset.
module dccm_tlul
  import tlul_pkg::*;
  import dccm_pkg::*;
#(
  parameter int unsigned Depth       = 1024,
  parameter int unsigned ReadLatency = 1,
  parameter int unsigned Outstanding = 4,
  parameter bit          ZeroInit    = 1'b0
) (
  input  logic    clock,
  input  logic    rst_ni,
  input  tl_h2d_t tl_i,
  output tl_d2h_t tl_o
);

  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int IW = $clog2(Outstanding + 1);
  localparam logic [31:0] DepthW = 32'(Depth);

  if (ReadLatency < 1 || ReadLatency > MaxReadLatency || Outstanding < 1 || Depth < 1) begin : gen_param_err
    $error("dccm_tlul: illegal parameter combination");
  end

  logic [31:0]   mem [Depth];
  logic [AW-1:0] idx;
  dccm_state_e   state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic          a_ready_q, a_ready_d;
  logic          is_get, is_put, req_err, accept, d_hs;
  logic          push, fifo_valid;
  dccm_rsp_t     req_rsp, push_rsp, fifo_rsp;
  logic          unused_bits;

  assign idx = tl_i.a_address[AW+1:2];
  assign unused_bits = ^{tl_i.a_param, tl_i.a_user, tl_i.a_address[31:AW+2], tl_i.a_address[1:0]};

  always_comb begin
    is_get  = (tl_i.a_opcode == Get);
    is_put  = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
    req_err = (32'(idx) >= DepthW) || !(is_get || is_put) || (tl_i.a_size > 2'd2);
    accept  = tl_i.a_valid && a_ready_q;
    req_rsp        = '0;
    req_rsp.opcode = is_get ? AccessAckData : AccessAck;
    req_rsp.size   = tl_i.a_size;
    req_rsp.source = tl_i.a_source;
    req_rsp.error  = req_err;
    if (is_get && !req_err) begin
      req_rsp.data = mem[idx];
    end
  end

  // Zero-fill and traffic never overlap: a_ready is held low while in INIT.
  always_ff @(posedge clock) begin
    if (state_q == INIT) begin
      mem[cnt_q] <= '0;
    end else if (accept && is_put && !req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (tl_i.a_mask[b]) begin
          mem[idx][8*b +: 8] <= tl_i.a_data[8*b +: 8];
        end
      end
    end
  end

  if (ReadLatency == 1) begin : gen_lat1
    assign push     = accept;
    assign push_rsp = req_rsp;
  end else begin : gen_lat2
    logic      pipe_vld_q;
    dccm_rsp_t pipe_q;

    always_ff @(posedge clock or negedge rst_ni) begin
      if (!rst_ni) begin
        pipe_vld_q <= 1'b0;
        pipe_q     <= '0;
      end else begin
        pipe_vld_q <= accept;
        pipe_q     <= req_rsp;
      end
    end

    assign push     = pipe_vld_q;
    assign push_rsp = pipe_q;
  end

  dccm_rsp_fifo #(
    .Depth (Outstanding)
  ) u_rsp_fifo (
    .clk_i   (clock),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (push_rsp),
    .ready_i (tl_i.d_ready),
    .valid_o (fifo_valid),
    .rdata_o (fifo_rsp)
  );

  assign d_hs = fifo_valid && tl_i.d_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == AW'(Depth - 1)) begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end
    inflight_d = inflight_q + IW'(accept) - IW'(d_hs);
    a_ready_d  = (state_d == RUN) && (inflight_d < IW'(Outstanding));
  end

  always_ff @(posedge clock or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ZeroInit ? INIT : RUN;
      cnt_q      <= '0;
      inflight_q <= '0;
      a_ready_q  <= !ZeroInit;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      a_ready_q  <= a_ready_d;
    end
  end

  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = fifo_valid;
    tl_o.d_opcode = fifo_rsp.opcode;
    tl_o.d_size   = fifo_rsp.size;
    tl_o.d_source = fifo_rsp.source;
    tl_o.d_data   = fifo_rsp.data;
    tl_o.d_error  = fifo_rsp.error;
    tl_o.a_ready  = a_ready_q;
  end

endmodule
